// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and helpers for the seven-segment BCD scheduler.
//   state_e   : conversion FSM states (IDLE, SHIFT, COMMIT)
//   NDIGITS   : number of display digits driven
//   MAX_VALUE : largest value that can be shown; larger inputs saturate here
//   dd_adjust : double-dabble add-3 step applied to every BCD nibble
//   lz_mask   : leading-zero blank mask for a packed BCD word (digit0 never blank)
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  localparam int NDIGITS   = 4;
  localparam int MAX_VALUE = 9999;

  // Any nibble of 5 or more would exceed 9 after the next doubling, so it is
  // pre-corrected by 3 to carry cleanly into the next decade.
  function automatic logic [4*NDIGITS-1:0] dd_adjust(input logic [4*NDIGITS-1:0] bcd);
    logic [4*NDIGITS-1:0] res;
    res = bcd;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  // A digit is blanked only if it and every more-significant digit are zero.
  function automatic logic [NDIGITS-1:0] lz_mask(input logic [4*NDIGITS-1:0] bcd);
    logic [NDIGITS-1:0] m;
    m = '0;
    m[NDIGITS-1] = (bcd[4*NDIGITS-1 -: 4] == 4'd0);
    for (int i = NDIGITS - 2; i >= 1; i--) begin
      m[i] = m[i+1] & (bcd[4*i +: 4] == 4'd0);
    end
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/seg7_blink_timer.sv
// -----------------------------------------------------------------------------
// seg7_blink_timer
// Half-period counter plus phase flop used to blink the display.
//   clk_clk     in  system clock
//   reset_reset in  synchronous, active-high reset
//   en_i        in  blinking requested; low clears the counter and forces phase on
//   phase_on_o  out 1 = show the committed blank mask, 0 = force all digits off
// Parameter DIV: clock cycles per blink half-period.
// -----------------------------------------------------------------------------
module seg7_blink_timer #(
  parameter int DIV = 25_000_000
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic en_i,
  output logic phase_on_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_on_o = phase_q;

endmodule

// File: rtl/seg7_bcd_scheduler.sv
// -----------------------------------------------------------------------------
// seg7_bcd_scheduler
// Accepts one binary value per valid/ready handshake, converts it to four BCD
// digits with a sequential double-dabble FSM (IDLE -> SHIFT -> COMMIT), and
// drives registered digits, a leading-zero blank mask and an overflow flag.
// Values above 9999 saturate to 9999 with overflow set.
//   clk_clk      in   system clock
//   reset_reset  in   synchronous, active-high reset
//   in_valid     in   in_value is presented
//   in_ready     out  ready to accept (high only in IDLE)
//   in_value     in   IN_W-bit unsigned value
//   digit0..3    out  BCD digits (digit0 = ones), registered
//   blank        out  per-digit blank mask
//   overflow     out  last committed value exceeded 9999
//   busy         out  conversion in progress
//   blink_en     in   blink request (only when SEG7_BLINK_EN is defined)
// Optional feature macro: SEG7_BLINK_EN adds blink_en, parameter BLINK_DIV and
// a seg7_blink_timer that forces blank to 4'b1111 during the off phase.
// -----------------------------------------------------------------------------
module seg7_bcd_scheduler
  import seg7_pkg::*;
#(
  parameter int IN_W     = 14,
  parameter bit LZ_BLANK = 1'b1
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
`ifdef SEG7_BLINK_EN
  input  logic            blink_en,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_value,
  output logic [3:0]      digit0,
  output logic [3:0]      digit1,
  output logic [3:0]      digit2,
  output logic [3:0]      digit3,
  output logic [3:0]      blank,
  output logic            overflow,
  output logic            busy
);

  localparam int              CNT_W     = $clog2(IN_W + 1);
  localparam int              BCD_W     = 4 * NDIGITS;
  localparam logic [NDIGITS-1:0] BLANK_RST = LZ_BLANK ? 4'b1110 : 4'b0000;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    shreg_q, shreg_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [NDIGITS-1:0] blank_q, blank_d;
  logic               overflow_q, overflow_d;

  logic               ovf_in;
  logic [IN_W-1:0]    sat_value;

  assign ovf_in    = 32'(in_value) > 32'(MAX_VALUE);
  assign sat_value = ovf_in ? IN_W'(MAX_VALUE) : in_value;

  // NOTE: every signal written here gets its hold value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d    = sat_value;
          ovf_pend_d = ovf_in;
          bcd_d      = '0;
          cnt_d      = CNT_W'(IN_W);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {dd_adjust(bcd_q), shreg_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        // Outputs update only here, so a half-converted value is never shown.
        disp_d     = bcd_q;
        blank_d    = LZ_BLANK ? lz_mask(bcd_q) : '0;
        overflow_d = ovf_pend_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      // NOTE: the shift datapath is reset too; it is a handful of flops and
      // keeps an aborted conversion from leaving stale bits behind.
      shreg_q    <= '0;
      bcd_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      blank_q    <= BLANK_RST;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign digit0   = disp_q[3:0];
  assign digit1   = disp_q[7:4];
  assign digit2   = disp_q[11:8];
  assign digit3   = disp_q[15:12];
  assign overflow = overflow_q;

`ifdef SEG7_BLINK_EN
  logic phase_on;

  seg7_blink_timer #(
    .DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .en_i        (blink_en),
    .phase_on_o  (phase_on)
  );

  assign blank = phase_on ? blank_q : 4'b1111;
`else
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_seg7_bcd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg7_bcd_scheduler
// Directed self-checking bench for seg7_bcd_scheduler (IN_W=14, LZ_BLANK=1).
// The blink scenario is compiled in when SEG7_BLINK_EN is defined.
// -----------------------------------------------------------------------------
module tb_seg7_bcd_scheduler;

  localparam int IN_W = 14;

  logic            clk_clk = 1'b0;
  logic            reset_reset;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_value;
  logic [3:0]      digit0, digit1, digit2, digit3;
  logic [3:0]      blank;
  logic            overflow;
  logic            busy;
`ifdef SEG7_BLINK_EN
  logic            blink_en;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Expected display state (bench model of what was last committed).
  logic [15:0] m_disp;
  logic [3:0]  m_blank;
  logic        m_ovf;

  logic [15:0] disp;
  assign disp = {digit3, digit2, digit1, digit0};

  seg7_bcd_scheduler #(
    .IN_W      (IN_W),
    .LZ_BLANK  (1'b1)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_DIV (4)
`endif
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
`ifdef SEG7_BLINK_EN
    .blink_en    (blink_en),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .blank       (blank),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      tick();
      k++;
    end
    check({name, ":ready"}, 32'(in_ready), 32'd1);
  endtask

  // One handshake plus full conversion; checks latency, output hold during
  // conversion, and the committed result. With glitch set, in_valid is pulsed
  // with 8888 mid-conversion, which must be ignored.
  task automatic send(input string name, input int v, input bit glitch,
                      input logic [15:0] e_disp, input logic [3:0] e_blank,
                      input logic e_ovf);
    int lat;
    wait_ready(name);
    in_valid = 1'b1;
    in_value = IN_W'(v);
    tick();
    in_valid = 1'b0;
    check({name, ":busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!in_ready && lat < 40) begin
      if (lat == IN_W) begin
        check({name, ":hold_disp"}, 32'(disp), 32'(m_disp));
        check({name, ":hold_ovf"}, 32'(overflow), 32'(m_ovf));
      end
      if (glitch && lat == 3) begin
        in_valid = 1'b1;
        in_value = 14'd8888;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({name, ":latency"}, 32'(lat), 32'(IN_W + 1));
    check({name, ":digits"}, 32'(disp), 32'(e_disp));
    check({name, ":blank"}, 32'(blank), 32'(e_blank));
    check({name, ":overflow"}, 32'(overflow), 32'(e_ovf));
    m_disp  = e_disp;
    m_blank = e_blank;
    m_ovf   = e_ovf;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_reset = 1'b1;
    in_valid    = 1'b0;
    in_value    = '0;
`ifdef SEG7_BLINK_EN
    blink_en    = 1'b0;
`endif
    repeat (2) tick();
    reset_reset = 1'b0;

    // Reset state
    check("rst:digits", 32'(disp), 32'h0000);
    check("rst:blank", 32'(blank), 32'he);
    check("rst:overflow", 32'(overflow), 32'd0);
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:busy", 32'(busy), 32'd0);
    m_disp  = 16'h0000;
    m_blank = 4'b1110;
    m_ovf   = 1'b0;

    // Basic conversions and leading-zero blanking
    send("v1234", 1234, 1'b0, 16'h1234, 4'b0000, 1'b0);
    send("v7",    7,    1'b0, 16'h0007, 4'b1110, 1'b0);
    send("v0",    0,    1'b0, 16'h0000, 4'b1110, 1'b0);
    send("v305",  305,  1'b0, 16'h0305, 4'b1000, 1'b0);

    // Saturation boundaries
    send("v12000", 12000, 1'b0, 16'h9999, 4'b0000, 1'b1);
    send("v10000", 10000, 1'b0, 16'h9999, 4'b0000, 1'b1);
    send("v9999",  9999,  1'b0, 16'h9999, 4'b0000, 1'b0);
    send("v16383", 16383, 1'b0, 16'h9999, 4'b0000, 1'b1);
    send("v9999b", 9999,  1'b0, 16'h9999, 4'b0000, 1'b0);

    // Reset during SHIFT cycle 5 of a 4321 conversion
    wait_ready("v4321");
    in_valid = 1'b1;
    in_value = 14'd4321;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abort:busy_before", 32'(busy), 32'd1);
    reset_reset = 1'b1;
    tick();
    check("abort:digits", 32'(disp), 32'h0000);
    check("abort:blank", 32'(blank), 32'he);
    check("abort:overflow", 32'(overflow), 32'd0);
    check("abort:in_ready", 32'(in_ready), 32'd1);
    check("abort:busy", 32'(busy), 32'd0);
    reset_reset = 1'b0;
    m_disp  = 16'h0000;
    m_blank = 4'b1110;
    m_ovf   = 1'b0;
    tick();
    check("abort:digits_after", 32'(disp), 32'h0000);
    send("v56", 56, 1'b0, 16'h0056, 4'b1100, 1'b0);

    // in_valid pulse while busy is ignored
    send("v250_glitch", 250, 1'b1, 16'h0250, 4'b1000, 1'b0);
    repeat (3) tick();
    check("glitch:busy_idle", 32'(busy), 32'd0);
    check("glitch:digits_stable", 32'(disp), 32'h0250);

`ifdef SEG7_BLINK_EN
    // Blink: 4 cycles on, 4 off, with BLINK_DIV=4
    send("v42", 42, 1'b0, 16'h0042, 4'b1100, 1'b0);
    blink_en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      check($sformatf("blink:k%0d", k), 32'(blank),
            ((k / 4) % 2 == 0) ? 32'hc : 32'hf);
      if (k < 13) tick();
    end
    blink_en = 1'b0;
    tick();
    check("blink:off_restore", 32'(blank), 32'hc);
    check("blink:digits", 32'(disp), 32'h0042);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
